// File: rtl/iowrite_display.sv
// CPU write-side I/O port: LED register plus a 4-digit multiplexed
// seven-segment display showing a 16-bit value in hex.
module iowrite_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iow,
    input  logic [1:0]  ioaddr,
    input  logic [15:0] iowrite_data,
    output logic [15:0] led,
    output logic [3:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [1:0] ADDR_LED  = 2'b00;
    localparam logic [1:0] ADDR_VAL  = 2'b01;
    localparam logic [1:0] ADDR_CTRL = 2'b10;

    logic [15:0]      r_led;
    logic [15:0]      r_value;
    logic [4:0]       r_ctrl;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [3:0]       r_seg_an;
    logic [7:0]       r_seg_cat;

    logic [3:0]       w_nib;
    logic [6:0]       w_hex;
    logic             w_lit;
    logic [3:0]       w_an_next;
    logic [7:0]       w_cat_next;

    // Register file; only control bits [4:0] have any effect, so only they are kept
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_led   <= 16'h0000;
            r_value <= 16'h0000;
            r_ctrl  <= 5'h00;
        end else if (iow) begin
            case (ioaddr)
                ADDR_LED:  r_led   <= iowrite_data;
                ADDR_VAL:  r_value <= iowrite_data;
                ADDR_CTRL: r_ctrl  <= iowrite_data[4:0];
                default:   ;
            endcase
        end
    end

    // Free-running digit scan, independent of writes and enable
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_comb begin
        w_nib = 4'h0;
        w_hex = 7'h00;
        case (r_idx)
            2'd0:    w_nib = r_value[3:0];
            2'd1:    w_nib = r_value[7:4];
            2'd2:    w_nib = r_value[11:8];
            default: w_nib = r_value[15:12];
        endcase
        case (w_nib)
            4'h0: w_hex = 7'h3F;
            4'h1: w_hex = 7'h06;
            4'h2: w_hex = 7'h5B;
            4'h3: w_hex = 7'h4F;
            4'h4: w_hex = 7'h66;
            4'h5: w_hex = 7'h6D;
            4'h6: w_hex = 7'h7D;
            4'h7: w_hex = 7'h07;
            4'h8: w_hex = 7'h7F;
            4'h9: w_hex = 7'h6F;
            4'hA: w_hex = 7'h77;
            4'hB: w_hex = 7'h7C;
            4'hC: w_hex = 7'h39;
            4'hD: w_hex = 7'h5E;
            4'hE: w_hex = 7'h79;
            default: w_hex = 7'h71;
        endcase
    end

    // A dark digit releases both anode and cathodes; dp is never driven
    always_comb begin
        w_lit      = r_ctrl[4] & ~r_ctrl[r_idx];
        w_an_next  = 4'hF;
        w_cat_next = 8'hFF;
        if (w_lit) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_cat_next = {1'b1, ~w_hex};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_seg_an  <= 4'hF;
            r_seg_cat <= 8'hFF;
        end else begin
            r_seg_an  <= w_an_next;
            r_seg_cat <= w_cat_next;
        end
    end

    assign led     = r_led;
    assign seg_an  = r_seg_an;
    assign seg_cat = r_seg_cat;

endmodule

// File: tb/tb_iowrite_display.sv
// Randomized self-checking bench for iowrite_display against an
// elapsed-cycle reference model of the scan and register writes.
module tb_iowrite_display;

    localparam int unsigned DIV = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iow = 1'b0;
    logic [1:0]  ioaddr = 2'b00;
    logic [15:0] iowrite_data = 16'h0000;
    logic [15:0] led;
    logic [3:0]  seg_an;
    logic [7:0]  seg_cat;

    int checks = 0;
    int errors = 0;

    iowrite_display #(.SCAN_DIV(DIV)) dut (
        .clock        (clock),
        .reset        (reset),
        .iow          (iow),
        .ioaddr       (ioaddr),
        .iowrite_data (iowrite_data),
        .led          (led),
        .seg_an       (seg_an),
        .seg_cat      (seg_cat)
    );

    always #5 clock = ~clock;

    // Reference model: digit index derived from edges elapsed since reset
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int unsigned m_cnt;
    logic [15:0] m_led, m_value, m_ctrl;
    logic [3:0]  m_an;
    logic [7:0]  m_cat;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cnt = 0; m_led = 0; m_value = 0; m_ctrl = 0;
            m_an = 4'hF; m_cat = 8'hFF;
        end else begin
            int unsigned n;
            logic [3:0] nib;
            n = (m_cnt / DIV) % 4;
            nib = 4'((m_value >> (4 * n)) & 16'hF);
            if (m_ctrl[4] && !m_ctrl[n]) begin
                m_an  = 4'hF ^ 4'(1 << n);
                m_cat = 8'hFF ^ {1'b0, hex_tab[nib]};
            end else begin
                m_an = 4'hF; m_cat = 8'hFF;
            end
            if (iow) begin
                if (ioaddr == 2'b00) m_led = iowrite_data;
                else if (ioaddr == 2'b01) m_value = iowrite_data;
                else if (ioaddr == 2'b10) m_ctrl = iowrite_data;
            end
            m_cnt = m_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] a, input logic [15:0] d);
        iow = w; ioaddr = a; iowrite_data = d;
    endtask

    task automatic test_reset();
        drive(1'b1, 2'b00, 16'hBEEF);
        step();
        drive(1'b1, 2'b10, 16'h0010);
        step();
        drive(1'b0, 2'b00, 16'h0000);
        repeat (5) step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (led !== 16'h0000 || seg_an !== 4'hF || seg_cat !== 8'hFF) begin
            errors++;
            $display("FAIL reset_async: led=%h an=%h cat=%h required 0000/F/FF", led, seg_an, seg_cat);
        end
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 2'b01, 16'h12F0);
        step();
        drive(1'b1, 2'b10, 16'h0010);
        step();
        drive(1'b0, 2'b00, 16'h0000);
        step();
        checks++;
        if (seg_an !== 4'hE || seg_cat !== 8'hC0) begin
            errors++;
            $display("FAIL reset_first_digit: an=%h cat=%h required E/C0", seg_an, seg_cat);
        end
    endtask

    task automatic test_led_write();
        drive(1'b1, 2'b00, 16'hA5A5);
        step();
        drive(1'b0, 2'b00, 16'h0000);
        checks++;
        if (led !== 16'hA5A5) begin
            errors++;
            $display("FAIL led_write: led=%h required A5A5", led);
        end
        drive(1'b1, 2'b11, 16'h1234);
        step();
        drive(1'b0, 2'b00, 16'h0000);
        checks++;
        if (led !== 16'hA5A5 || seg_an !== m_an || seg_cat !== m_cat) begin
            errors++;
            $display("FAIL unmapped_write: led=%h an=%h cat=%h required A5A5/%h/%h", led, seg_an, seg_cat, m_an, m_cat);
        end
    endtask

    task automatic run_check(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            checks++;
            if (led !== m_led || seg_an !== m_an || seg_cat !== m_cat) begin
                errors++;
                $display("FAIL %s cyc %0d: led=%h an=%h cat=%h required %h/%h/%h", name, i, led, seg_an, seg_cat, m_led, m_an, m_cat);
            end
        end
    endtask

    task automatic test_scan();
        int seen;
        drive(1'b1, 2'b01, 16'h12F0);
        step();
        drive(1'b1, 2'b10, 16'h0010);
        step();
        drive(1'b0, 2'b00, 16'h0000);
        step();
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if ((seg_an == 4'hE && seg_cat == 8'hC0) || (seg_an == 4'hD && seg_cat == 8'h8E) ||
                (seg_an == 4'hB && seg_cat == 8'hA4) || (seg_an == 4'h7 && seg_cat == 8'hF9))
                seen++;
        end
        checks++;
        if (seen != 16) begin
            errors++;
            $display("FAIL scan_patterns: %0d of 16 cycles matched a lit 12F0 digit, required 16", seen);
        end
        run_check("scan", 24);
    endtask

    task automatic test_mask();
        int dark;
        drive(1'b1, 2'b10, 16'h0015);
        step();
        drive(1'b0, 2'b00, 16'h0000);
        step();
        dark = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (seg_an == 4'hF && seg_cat == 8'hFF) dark++;
        end
        checks++;
        if (dark != 8) begin
            errors++;
            $display("FAIL mask_dark_count: %0d dark cycles of 16, required 8", dark);
        end
        run_check("mask", 16);
    endtask

    task automatic test_disable();
        drive(1'b1, 2'b10, 16'h0000);
        step();
        drive(1'b0, 2'b00, 16'h0000);
        step();
        for (int i = 0; i < 13; i++) begin
            step();
            checks++;
            if (seg_an !== 4'hF || seg_cat !== 8'hFF) begin
                errors++;
                $display("FAIL disable cyc %0d: an=%h cat=%h required F/FF", i, seg_an, seg_cat);
            end
        end
        drive(1'b1, 2'b10, 16'h0010);
        step();
        drive(1'b0, 2'b00, 16'h0000);
        run_check("reenable", 16);
    endtask

    task automatic test_held_strobe();
        drive(1'b1, 2'b01, 16'h1111);
        step();
        drive(1'b1, 2'b01, 16'h2222);
        step();
        drive(1'b1, 2'b01, 16'h3333);
        step();
        drive(1'b0, 2'b00, 16'h0000);
        run_check("held_strobe", 16);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 16'($urandom));
            if (ioaddr == 2'b10 && ($urandom_range(0, 1) == 1))
                iowrite_data[4] = 1'b1;
            step();
            checks++;
            if (led !== m_led || seg_an !== m_an || seg_cat !== m_cat) begin
                errors++;
                $display("FAIL random cyc %0d: led=%h an=%h cat=%h required %h/%h/%h", i, led, seg_an, seg_cat, m_led, m_an, m_cat);
            end
        end
        drive(1'b0, 2'b00, 16'h0000);
    endtask

    initial begin
        #12 reset = 1'b1;
        test_reset();
        test_led_write();
        test_scan();
        test_mask();
        test_disable();
        test_held_strobe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
